// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg
//   Shared types and constants for the SLC-3 memory responder slice:
//   - word_t   : 16-bit data word
//   - IO_ADDR  : word address of the memory-mapped switch/display register
//   - state_t  : responder FSM states (IDLE, WAIT, DONE)
package slc3_mem_pkg;

  typedef logic [15:0] word_t;

  localparam logic [19:0] IO_ADDR = 20'h0FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slc3_mem_array.sv
// slc3_mem_array
//   Single-port MEM_WORDS x 16 backing store. Synchronous write, combinational
//   read, no reset (contents survive a responder reset).
// Ports:
//   clk    in   system clock
//   we     in   write enable, write lands on the rising edge
//   addr   in   word address, $clog2(MEM_WORDS) bits
//   wdata  in   write data
//   rdata  out  read data at addr (combinational)
module slc3_mem_array
  import slc3_mem_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  word_t                        wdata,
  output word_t                        rdata
);

  word_t mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder
//   Memory responder for the SLC-3 bus. An access is accepted in IDLE,
//   held for WAIT_CYCLES wait states, then completed in DONE with a
//   single-cycle ready strobe (err alongside it for unmapped addresses).
//   ready is high in the cycle following the (WAIT_CYCLES+1)-th rising edge
//   counted from, and including, the acceptance edge... i.e. it is sampled
//   high on the rising edge WAIT_CYCLES+1 edges after acceptance.
// Build option:
//   IO_MAP_EN  when defined, word address 20'h0FFFF reads the switches (S)
//              and writes the hex display register (hex_out). Otherwise that
//              address is ordinary (unmapped for MEM_WORDS <= 65535) and
//              hex_out stays 0.
// Parameters:
//   WAIT_CYCLES  wait states per access, 0..15
//   MEM_WORDS    backing store depth in 16-bit words, power of two, >= 2
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous active-low reset
//   req      in   access request, held until ready
//   we       in   1 = write, 0 = read (sampled at acceptance)
//   ADDR     in   20-bit word address (sampled at acceptance)
//   wdata    in   write data (sampled at acceptance)
//   S        in   board switch value
//   rdata    out  read data, non-zero only in the ready cycle
//   ready    out  completion strobe
//   err      out  unmapped-address strobe, coincident with ready
//   hex_out  out  display register
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_WORDS   = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [19:0] ADDR,
  input  word_t       wdata,
  input  word_t       S,
  output word_t       rdata,
  output logic        ready,
  output logic        err,
  output word_t       hex_out
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [19:0]  addr_q, addr_d;
  word_t        wdata_q, wdata_d;

  logic         in_done;
  logic         io_hit;
  logic         mem_hit;
  logic         mem_sel;
  logic         mem_we;
  logic [AW-1:0] mem_addr;
  word_t        mem_rd;

  // Control state: cleared by reset, so an in-flight access simply vanishes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access fields captured at acceptance; only consumed in DONE.
  always_ff @(posedge Clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = ADDR;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          // Final decrement to zero coincides with the move to DONE.
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_done = (state_q == DONE);

`ifdef IO_MAP_EN
  assign io_hit = (addr_q == IO_ADDR);
`else
  assign io_hit = 1'b0;
`endif

  // 21-bit compare so MEM_WORDS = 2**20 still works.
  assign mem_hit  = ({1'b0, addr_q} < 21'(MEM_WORDS));
  // The I/O address shadows memory if the store is ever large enough to reach it.
  assign mem_sel  = mem_hit && !io_hit;
  assign mem_we   = in_done && we_q && mem_sel;
  assign mem_addr = addr_q[AW-1:0];

  slc3_mem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rd)
  );

  always_comb begin
    rdata = '0;
    ready = 1'b0;
    err   = 1'b0;
    if (in_done) begin
      ready = 1'b1;
      err   = !(io_hit || mem_sel);
      if (!we_q) begin
        if (io_hit) begin
          rdata = S;
        end else if (mem_sel) begin
          rdata = mem_rd;
        end
      end
    end
  end

`ifdef IO_MAP_EN
  word_t hex_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hex_q <= '0;
    end else if (in_done && we_q && io_hit) begin
      hex_q <= wdata_q;
    end
  end

  assign hex_out = hex_q;
`else
  logic unused_s;

  assign unused_s = ^S;
  assign hex_out  = '0;
`endif

endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb_slc3_mem_responder
//   Bench for slc3_mem_responder: instance u_a (WAIT_CYCLES=2) carries the
//   table, random and reset/abort sequences; instance u_b (WAIT_CYCLES=0)
//   carries the back-to-back sequence. Honors IO_MAP_EN when defined.
module tb_slc3_mem_responder;

`ifdef IO_MAP_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  localparam int W_A  = 2;
  localparam int MEMW = 256;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_a, req_b, we;
  logic [19:0] ADDR;
  logic [15:0] wdata, S;
  logic [15:0] rdata_a, hex_a, rdata_b, hex_b;
  logic        ready_a, err_a, ready_b, err_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [MEMW];
  logic [15:0] hex_m;

  typedef struct {
    bit          w;
    logic [19:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  always #5 Clk = ~Clk;

  slc3_mem_responder #(.WAIT_CYCLES(W_A), .MEM_WORDS(MEMW)) u_a (
    .Clk(Clk), .Reset(Reset), .req(req_a), .we(we), .ADDR(ADDR),
    .wdata(wdata), .S(S), .rdata(rdata_a), .ready(ready_a), .err(err_a),
    .hex_out(hex_a)
  );

  slc3_mem_responder #(.WAIT_CYCLES(0), .MEM_WORDS(MEMW)) u_b (
    .Clk(Clk), .Reset(Reset), .req(req_b), .we(we), .ADDR(ADDR),
    .wdata(wdata), .S(S), .rdata(rdata_b), .ready(ready_b), .err(err_b),
    .hex_out(hex_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: address decode straight from the memory map.
  function automatic bit is_io(input logic [19:0] a);
    return IO_EN && (a == 20'h0FFFF);
  endfunction

  task automatic model(input bit w, input logic [19:0] a, input logic [15:0] d,
                       output logic [15:0] erd, output bit eerr);
    erd  = 16'h0000;
    eerr = 1'b0;
    if (is_io(a)) begin
      if (w) hex_m = d;
      else   erd = S;
    end else if (a < 20'(MEMW)) begin
      if (w) mem_m[a[7:0]] = d;
      else   erd = mem_m[a[7:0]];
    end else begin
      eerr = 1'b1;
    end
  endtask

  // One access from IDLE. Access inputs are scrambled while it is in flight.
  task automatic do_access(input bit sel, input bit w, input logic [19:0] a,
                           input logic [15:0] d, input int lat_exp,
                           output logic [15:0] rd, output logic e);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    rd  = 16'h0000;
    e   = 1'b0;
    we = w; ADDR = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    while (!got && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (sel ? ready_b : ready_a) begin
        got = 1'b1;
        rd  = sel ? rdata_b : rdata_a;
        e   = sel ? err_b : err_a;
      end else begin
        chk("idle_rdata", sel ? rdata_b : rdata_a, 16'h0000);
        chk("idle_err", sel ? err_b : err_a, 1'b0);
        we    = 1'($urandom);
        ADDR  = 20'($urandom);
        wdata = 16'($urandom);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("latency", 32'(lat), 32'(lat_exp));
    @(posedge Clk); #1;
    chk("ready_single", sel ? ready_b : ready_a, 1'b0);
    if (sel) chk("hex_out_b", hex_b, 16'h0000);
    else     chk("hex_out", hex_a, hex_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] rd, erd, prior;
    logic        e;
    bit          eerr, w;
    logic [19:0] a;
    logic [15:0] d;
    int          r;

    Reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
    ADDR = '0; wdata = '0; S = '0; hex_m = '0;

    // Asynchronous reset, asserted and checked before any clock edge.
    #2 Reset = 1'b0;
    #1;
    chk("rst_ready", ready_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_rdata", rdata_a, 16'h0000);
    chk("rst_hex", hex_a, 16'h0000);
    chk("rst_ready_b", ready_b, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Fill memory with known contents.
    for (int i = 0; i < MEMW; i++) begin
      d = 16'($urandom);
      model(1'b1, 20'(i), d, erd, eerr);
      do_access(1'b0, 1'b1, 20'(i), d, W_A + 1, rd, e);
      chk("fill_err", e, 1'b0);
    end

    // Directed table.
    S = 16'hABCD;
    tbl.push_back('{1'b1, 20'h00010, 16'h1234, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0});
    tbl.push_back('{1'b1, 20'h00000, 16'h0F0F, 16'h0000, 1'b0});
    tbl.push_back('{1'b1, 20'h000FF, 16'h7777, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 20'h00100, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{1'b1, 20'h00100, 16'h5A5A, 16'h0000, 1'b1});
    tbl.push_back('{1'b0, 20'h00000, 16'h0000, 16'h0F0F, 1'b0});
    tbl.push_back('{1'b0, 20'h0FFFF, 16'h0000, IO_EN ? 16'hABCD : 16'h0000, !IO_EN});
    tbl.push_back('{1'b1, 20'h0FFFF, 16'h00FF, 16'h0000, !IO_EN});
    tbl.push_back('{1'b0, 20'h000FF, 16'h0000, 16'h7777, 1'b0});
    tbl.push_back('{1'b0, 20'hFFFFF, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{1'b1, 20'h80010, 16'hDEAD, 16'h0000, 1'b1});
    tbl.push_back('{1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0});
    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, erd, eerr);
      do_access(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, W_A + 1, rd, e);
      chk("tbl_err", e, tbl[i].exp_err);
      if (!tbl[i].w) chk("tbl_rdata", rd, tbl[i].exp_rd);
    end
    chk("tbl_hex", hex_a, IO_EN ? 16'h00FF : 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 20'($urandom_range(0, MEMW - 1));
      else if (r == 7) a = 20'h0FFFF;
      else if (r == 8) a = 20'($urandom_range(MEMW, 20'hFFFFF));
      else             a = 20'hFFFFF;
      w = 1'($urandom);
      d = 16'($urandom);
      S = 16'($urandom);
      model(w, a, d, erd, eerr);
      do_access(1'b0, w, a, d, W_A + 1, rd, e);
      chk("rnd_err", e, eerr);
      if (!w) chk("rnd_rdata", rd, erd);
    end

    // Reset in the middle of a write: nothing lands, display clears.
    model(1'b1, 20'h0FFFF, 16'h1357, erd, eerr);
    do_access(1'b0, 1'b1, 20'h0FFFF, 16'h1357, W_A + 1, rd, e);
    prior = mem_m[8'h20];
    we = 1'b1; ADDR = 20'h00020; wdata = 16'hBEEF; req_a = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rstop_ready_wait", ready_a, 1'b0);
    #2 Reset = 1'b0;
    #1;
    chk("rstop_ready", ready_a, 1'b0);
    chk("rstop_hex", hex_a, 16'h0000);
    req_a = 1'b0;
    #1 Reset = 1'b1;
    hex_m = 16'h0000;
    @(posedge Clk); #1;
    do_access(1'b0, 1'b0, 20'h00020, 16'h0000, W_A + 1, rd, e);
    chk("rstop_rdata", rd, prior);
    chk("rstop_hex_after", hex_a, 16'h0000);

    // Drop req during WAIT: abort with no ready and no write.
    prior = mem_m[8'h30];
    we = 1'b1; ADDR = 20'h00030; wdata = ~prior; req_a = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("abort_ready", ready_a, 1'b0);
      chk("abort_err", err_a, 1'b0);
    end
    do_access(1'b0, 1'b0, 20'h00030, 16'h0000, W_A + 1, rd, e);
    chk("abort_rdata", rd, prior);

    // WAIT_CYCLES=0, req held high: ready every second cycle.
    do_access(1'b1, 1'b1, 20'h00001, 16'h1111, 1, rd, e);
    do_access(1'b1, 1'b1, 20'h00002, 16'h2222, 1, rd, e);
    we = 1'b0; ADDR = 20'h00001; req_b = 1'b1;
    @(posedge Clk); #1;
    chk("b2b_ready_1", ready_b, 1'b1);
    chk("b2b_rdata_1", rdata_b, 16'h1111);
    chk("b2b_err_1", err_b, 1'b0);
    ADDR = 20'h00002;
    @(posedge Clk); #1;
    chk("b2b_gap", ready_b, 1'b0);
    @(posedge Clk); #1;
    chk("b2b_ready_2", ready_b, 1'b1);
    chk("b2b_rdata_2", rdata_b, 16'h2222);
    req_b = 1'b0;
    @(posedge Clk); #1;
    chk("b2b_end", ready_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
